// File: rtl/diila_trig_seq.sv
// Multi-stage trigger sequencer for the logic analyzer: masked-compare stages with
// occurrence counts, configured over a Wishbone classic slave on the analyzer clock.
module diila_trig_seq #(
  parameter int unsigned STAGES     = 4,
  parameter int unsigned TRIG_WIDTH = 32
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [7:2]            wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic [TRIG_WIDTH-1:0] trig_i,
  output logic                  trig_hit_o,
  output logic                  armed_o,
  output logic                  fired_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  localparam logic [3:0] STAGES_L = 4'(STAGES);

  logic [TRIG_WIDTH-1:0] value_r [STAGES];
  logic [TRIG_WIDTH-1:0] mask_r  [STAGES];
  logic [15:0]           count_r [STAGES];
  logic [3:0]            nstages_r;

  state_t      state_r;
  logic [2:0]  stage_r;
  logic [15:0] occ_r;
  logic        trig_hit_r;
  logic        ack_r;

  logic [5:0]  adr;
  logic        wr_en;
  logic        ctrl_wr;
  logic        abort_wr;
  logic        arm_wr;
  logic [3:0]  nstages_wr;

  logic [TRIG_WIDTH-1:0] cur_val;
  logic [TRIG_WIDTH-1:0] cur_mask;
  logic [15:0]           cur_count;
  logic [15:0]           count_eff;
  logic [15:0]           occ_next;
  logic                  match;
  logic                  last_stage;

  logic unused_sel;
  assign unused_sel = ^wb_sel_i;

  assign adr      = wb_adr_i;
  assign wr_en    = wb_stb_i & wb_cyc_i & wb_we_i;
  assign ctrl_wr  = wr_en && (adr == 6'd0);
  assign abort_wr = ctrl_wr & wb_dat_i[1];
  assign arm_wr   = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1];

  always_comb begin
    nstages_wr = wb_dat_i[3:0];
    if (wb_dat_i[3:0] == 4'd0)
      nstages_wr = 4'd1;
    else if (wb_dat_i[3:0] > STAGES_L)
      nstages_wr = STAGES_L;
  end

  // Current-stage selection as a mux loop keeps the index in range for any STAGES.
  always_comb begin
    cur_val   = '0;
    cur_mask  = '0;
    cur_count = 16'd1;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (stage_r == 3'(k)) begin
        cur_val   = value_r[k];
        cur_mask  = mask_r[k];
        cur_count = count_r[k];
      end
    end
  end

  assign match      = ((trig_i & cur_mask) == (cur_val & cur_mask));
  assign count_eff  = (cur_count == 16'd0) ? 16'd1 : cur_count;
  assign occ_next   = (occ_r == 16'hFFFF) ? occ_r : occ_r + 16'd1;
  assign last_stage = ({1'b0, stage_r} + 4'd1) >= nstages_r;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      nstages_r <= 4'd1;
      for (int unsigned k = 0; k < STAGES; k++) begin
        value_r[k] <= '0;
        mask_r[k]  <= '0;
        count_r[k] <= 16'd1;
      end
    end else if (wr_en) begin
      if (adr == 6'd2)
        nstages_r <= nstages_wr;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (adr == 6'(16 + k)) value_r[k] <= wb_dat_i[TRIG_WIDTH-1:0];
        if (adr == 6'(32 + k)) mask_r[k]  <= wb_dat_i[TRIG_WIDTH-1:0];
        if (adr == 6'(48 + k)) count_r[k] <= wb_dat_i[15:0];
      end
    end
  end

  // Control writes take priority over sequencing, so a completing match on the
  // same cycle as an arm/abort write never produces a pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= IDLE;
      stage_r    <= '0;
      occ_r      <= '0;
      trig_hit_r <= 1'b0;
    end else begin
      trig_hit_r <= 1'b0;
      if (abort_wr) begin
        state_r <= IDLE;
        stage_r <= '0;
        occ_r   <= '0;
      end else if (arm_wr) begin
        state_r <= ARMED;
        stage_r <= '0;
        occ_r   <= '0;
      end else if (state_r == ARMED && match) begin
        if (occ_next < count_eff) begin
          occ_r <= occ_next;
        end else if (!last_stage) begin
          stage_r <= stage_r + 3'd1;
          occ_r   <= '0;
        end else begin
          state_r    <= FIRED;
          trig_hit_r <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      ack_r <= 1'b0;
    else
      ack_r <= ~ack_r & wb_stb_i & wb_cyc_i;
  end

  always_comb begin
    wb_dat_o = '0;
    case (adr)
      6'd1:    wb_dat_o = {occ_r, 9'd0, stage_r, 2'd0, state_r};
      6'd2:    wb_dat_o = {28'd0, nstages_r};
      default: begin
        for (int unsigned k = 0; k < STAGES; k++) begin
          if (adr == 6'(16 + k)) wb_dat_o = 32'(value_r[k]);
          if (adr == 6'(32 + k)) wb_dat_o = 32'(mask_r[k]);
          if (adr == 6'(48 + k)) wb_dat_o = {16'd0, count_r[k]};
        end
      end
    endcase
  end

  assign wb_ack_o   = ack_r;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign trig_hit_o = trig_hit_r;
  assign armed_o    = (state_r == ARMED);
  assign fired_o    = (state_r == FIRED);

endmodule

// File: tb/tb_diila_trig_seq.sv
// Directed bench for diila_trig_seq: register map, stage sequencing, abort/arm
// collisions, NSTAGES clamping and reset behaviour.
module tb_diila_trig_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_rty;
  logic [31:0] trig = '0;
  logic        hit;
  logic        armed;
  logic        fired;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic        last_hit;
  logic [31:0] rd;

  diila_trig_seq #(.STAGES(4), .TRIG_WIDTH(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wb_adr_i  (wb_adr),
    .wb_dat_i  (wb_dat),
    .wb_sel_i  (wb_sel),
    .wb_we_i   (wb_we),
    .wb_cyc_i  (wb_cyc),
    .wb_stb_i  (wb_stb),
    .wb_dat_o  (wb_rdat),
    .wb_ack_o  (wb_ack),
    .wb_err_o  (wb_err),
    .wb_rty_o  (wb_rty),
    .trig_i    (trig),
    .trig_hit_o(hit),
    .armed_o   (armed),
    .fired_o   (fired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Strobe for one cycle, then one idle cycle so every access gets its own ack.
  task automatic wb_wr(input logic [5:0] a, input logic [31:0] d);
    wb_adr = a; wb_dat = d; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick;
    last_hit = hit;
    chk("wr_ack", 32'(wb_ack), 32'd1);
    wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    trig = '0;
    tick;
    chk("wr_ack_clr", 32'(wb_ack), 32'd0);
  endtask

  task automatic wb_rd(input logic [5:0] a, output logic [31:0] d);
    wb_adr = a; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    #1 d = wb_rdat;
    tick;
    chk("rd_ack", 32'(wb_ack), 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    trig = '0;
    tick;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic step(input string tag, input logic [31:0] v, input logic exp_hit);
    trig = v;
    tick;
    chk(tag, 32'(hit), 32'(exp_hit));
    trig = '0;
  endtask

  initial begin
    // Reset state and register reset values
    tick; tick;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_fired", 32'(fired), 32'd0);
    chk("rst_ack", 32'(wb_ack), 32'd0);
    rst = 1'b0;
    rd_chk("rst_nstages", 6'd2, 32'd1);
    rd_chk("rst_count0", 6'd48, 32'd1);
    rd_chk("rst_status", 6'd1, 32'd0);

    // Single stage, one match
    wb_wr(6'd32, 32'hFFFF_FFFF);
    wb_wr(6'd16, 32'h0000_00A5);
    wb_wr(6'd0, 32'd1);
    chk("t1_armed", 32'(armed), 32'd1);
    chk("t1_nohit", 32'(hit), 32'd0);
    step("t1_hit", 32'hA5, 1'b1);
    chk("t1_fired", 32'(fired), 32'd1);
    step("t1_hit_once", 32'h0, 1'b0);
    wb_rd(6'd1, rd);
    chk("t1_status_state", {30'd0, rd[1:0]}, 32'd2);

    // Three stages: 1 x2, 2 x1, 3 x3
    wb_wr(6'd2, 32'd3);
    wb_wr(6'd16, 32'd1); wb_wr(6'd48, 32'd2);
    wb_wr(6'd17, 32'd2); wb_wr(6'd33, 32'hFFFF_FFFF); wb_wr(6'd49, 32'd1);
    wb_wr(6'd18, 32'd3); wb_wr(6'd34, 32'hFFFF_FFFF); wb_wr(6'd50, 32'd3);
    wb_wr(6'd0, 32'd1);
    step("t2_s1", 32'd1, 1'b0);
    rd_chk("t2_st_a", 6'd1, 32'h0001_0001);
    step("t2_s2", 32'd0, 1'b0);
    step("t2_s3", 32'd1, 1'b0);
    rd_chk("t2_st_b", 6'd1, 32'h0000_0011);
    step("t2_s4", 32'd2, 1'b0);
    rd_chk("t2_st_c", 6'd1, 32'h0000_0021);
    step("t2_s5", 32'd3, 1'b0);
    rd_chk("t2_st_d", 6'd1, 32'h0001_0021);
    step("t2_s6", 32'd9, 1'b0);
    step("t2_s7", 32'd3, 1'b0);
    step("t2_s8", 32'd3, 1'b1);
    chk("t2_fired", 32'(fired), 32'd1);

    // Constant match: stage advance costs one cycle
    wb_wr(6'd2, 32'd2);
    wb_wr(6'd48, 32'd1);
    wb_wr(6'd17, 32'd1);
    wb_wr(6'd0, 32'd1);
    step("t3_first", 32'd1, 1'b0);
    step("t3_second", 32'd1, 1'b1);

    // Abort mid-sequence at stage 1, occ 2
    wb_wr(6'd2, 32'd3);
    wb_wr(6'd16, 32'd1);
    wb_wr(6'd17, 32'd2); wb_wr(6'd49, 32'd5);
    wb_wr(6'd0, 32'd1);
    step("t4_a", 32'd1, 1'b0);
    step("t4_b", 32'd2, 1'b0);
    step("t4_c", 32'd2, 1'b0);
    rd_chk("t4_status", 6'd1, 32'h0002_0011);
    wb_wr(6'd0, 32'd3);
    chk("t4_abort_nohit", 32'(last_hit), 32'd0);
    chk("t4_abort_armed", 32'(armed), 32'd0);
    rd_chk("t4_status_idle", 6'd1, 32'd0);
    step("t4_idle_a", 32'd1, 1'b0);
    step("t4_idle_b", 32'd2, 1'b0);
    chk("t4_idle_fired", 32'(fired), 32'd0);

    // Control writes coinciding with a final-stage completion
    wb_wr(6'd2, 32'd1);
    wb_wr(6'd0, 32'd1);
    trig = 32'd1;
    wb_wr(6'd0, 32'd2);
    chk("t5_abort_coll_hit", 32'(last_hit), 32'd0);
    chk("t5_abort_coll_armed", 32'(armed), 32'd0);
    chk("t5_abort_coll_fired", 32'(fired), 32'd0);
    wb_wr(6'd0, 32'd1);
    trig = 32'd1;
    wb_wr(6'd0, 32'd1);
    chk("t5_arm_coll_hit", 32'(last_hit), 32'd0);
    chk("t5_arm_coll_armed", 32'(armed), 32'd1);
    step("t5_rearm_hit", 32'd1, 1'b1);
    wb_wr(6'd0, 32'd3);
    chk("t5_both_fired", 32'(fired), 32'd0);
    chk("t5_both_armed", 32'(armed), 32'd0);

    // NSTAGES clamping, COUNT of zero, unmapped address
    wb_wr(6'd2, 32'd0);
    rd_chk("t6_nst0", 6'd2, 32'd1);
    wb_wr(6'd2, 32'd15);
    rd_chk("t6_nst15", 6'd2, 32'd4);
    wb_wr(6'd2, 32'd1);
    wb_wr(6'd48, 32'd0);
    rd_chk("t6_count0", 6'd48, 32'd0);
    wb_wr(6'd0, 32'd1);
    step("t6_cnt0_hit", 32'd1, 1'b1);
    wb_wr(6'd60, 32'hDEAD_BEEF);
    rd_chk("t6_unmapped", 6'd60, 32'd0);
    rd_chk("t6_ctrl_rd", 6'd0, 32'd0);

    // NSTAGES reduced below the current stage while armed
    wb_wr(6'd2, 32'd3);
    wb_wr(6'd48, 32'd1);
    wb_wr(6'd17, 32'd2); wb_wr(6'd49, 32'd1);
    wb_wr(6'd50, 32'd1);
    wb_wr(6'd0, 32'd1);
    step("t7_a", 32'd1, 1'b0);
    step("t7_b", 32'd2, 1'b0);
    wb_wr(6'd2, 32'd2);
    step("t7_fire", 32'd3, 1'b1);

    // Reset while armed at stage 2
    wb_wr(6'd2, 32'd3);
    wb_wr(6'd0, 32'd1);
    step("t8_a", 32'd1, 1'b0);
    step("t8_b", 32'd2, 1'b0);
    rd_chk("t8_status", 6'd1, 32'h0000_0021);
    rst = 1'b1;
    trig = 32'd3;
    tick;
    chk("t8_rst_hit", 32'(hit), 32'd0);
    tick;
    rst = 1'b0;
    trig = '0;
    chk("t8_rst_armed", 32'(armed), 32'd0);
    rd_chk("t8_nstages", 6'd2, 32'd1);
    rd_chk("t8_value0", 6'd16, 32'd0);
    rd_chk("t8_mask0", 6'd32, 32'd0);
    rd_chk("t8_count1", 6'd49, 32'd1);
    rd_chk("t8_status_idle", 6'd1, 32'd0);
    step("t8_idle", 32'd3, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/diila_trig_seq.md
Name: diila_trig_seq

Overview:
- Multi-stage trigger sequencer that decides when the logic analyzer's capture trigger fires.
- Watches the same 32-bit trigger bus the analyzer logs.
- Steps through up to STAGES masked-compare conditions, each with an occurrence count.
- Emits a one-cycle trigger pulse to the analyzer capture logic.
- Configured and monitored over a Wishbone classic slave on the analyzer clock.

Parameters:
STAGES, 4, number of sequencer stages (1..8)
TRIG_WIDTH, 32, width of trig_i; values and masks use bits [TRIG_WIDTH-1:0]

Ports:
wb_clk_i  in  1  clock; all logic is in this domain
wb_rst_i  in  1  synchronous active-high reset
wb_adr_i  in  [7:2]  word address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects (ignored; full-word access only)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data, combinational from wb_adr_i
wb_ack_o  out  1  acknowledge
wb_err_o  out  1  tied 0
wb_rty_o  out  1  tied 0
trig_i  in  TRIG_WIDTH  monitored trigger bus
trig_hit_o  out  1  one-cycle pulse when the final stage completes
armed_o  out  1  high in state ARMED
fired_o  out  1  high in state FIRED

Behaviour:
- Register map, word index = wb_adr_i[7:2]:
  - 0 CTRL (W): bit0 arm, bit1 abort. Reads return 0.
  - 1 STATUS (R): [1:0] state (0 IDLE, 1 ARMED, 2 FIRED); [6:4] current stage; [31:16] occurrence counter.
  - 2 NSTAGES (RW): [3:0]. A written 0 is stored as 1; values above STAGES are stored as STAGES. Reset value is 1.
  - 16+k VALUE[k] (RW), reset 0.
  - 32+k MASK[k] (RW), reset 0.
  - 48+k COUNT[k] (RW), [15:0], reset 1. A COUNT of 0 behaves as 1.
  - Unmapped addresses read 0; writes to them are ignored.
- Write cycles: a write occurs on every cycle with stb & cyc & we, the same as the analyzer's config writes.
- Ack:
  - Set to 1 the cycle after stb & cyc when ack is 0.
  - Cleared on the following cycle.
  - Every access acks 1 cycle after strobe; back-to-back strobes ack every other cycle.
- Stage match: stage k matches when (trig_i & MASK[k]) == (VALUE[k] & MASK[k]). A MASK of 0 matches every cycle.
- FSM state IDLE:
  - Outputs low.
  - A CTRL arm write moves to ARMED with stage=0 and occ=0.
- FSM state ARMED: on each cycle where the current stage matches, occ_next = occ+1.
  - If occ_next < COUNT[stage]: occ <= occ_next.
  - Else, if stage < NSTAGES-1: stage <= stage+1 and occ <= 0. The new stage is first evaluated on the following cycle, so there is at most one stage advance per cycle.
  - Else: go to FIRED and pulse trig_hit_o high for exactly that one cycle (registered, so it is high the cycle after the matching trig_i sample).
  - A non-matching cycle holds both stage and occ. Matches need not be consecutive.
- FSM state FIRED:
  - Holds; fired_o=1.
  - An arm write restarts the sequence (ARMED, stage=0, occ=0).
- Abort: a CTRL abort write in any state goes to IDLE and clears stage and occ.
- Simultaneous events:
  - Arm and abort in one write: abort wins.
  - Abort or arm on the same cycle as a final-stage completion: the write wins and trig_hit_o stays low.
- Config writes while ARMED:
  - Take effect from the next cycle.
  - If NSTAGES is reduced to at or below the current stage, the next match of the current stage fires.
- occ saturates at 0xFFFF (COUNT is 16 bits, so this is unreachable beyond completion).
- Reset:
  - State IDLE, stage 0, occ 0, trig_hit_o 0, wb_ack_o 0; registers take their reset values.
  - Reset mid-sequence abandons it with no pulse.

Test Plan:
- Reset, then read NSTAGES, COUNT[0] and STATUS -> 1, 1, 0. Write MASK[0]=0xFFFFFFFF, VALUE[0]=0xA5, arm, then drive trig_i=0xA5 for one cycle -> trig_hit_o high for exactly 1 cycle, the cycle after the sample; fired_o=1; STATUS[1:0]=2.
- NSTAGES=3; stage0 value 0x1 count 2; stage1 value 0x2 count 1; stage2 value 0x3 count 3 (all full masks). Drive 1,0,1,2,3,9,3,3 -> fire after the 8th sample only. STATUS stage progresses 0→1→2 and occ resets at each advance.
- Hold trig_i=0x1 constantly with NSTAGES=2, stage0=stage1=0x1 count 1 -> fire on the 2nd matching cycle, not the 1st; stage advance costs 1 cycle.
- Armed at stage 1 with occ=2, write CTRL=0x3 -> IDLE, no pulse, STATUS=0; a following match does nothing.
- Write NSTAGES=0 reads back 1; NSTAGES=15 reads back 4; COUNT[0]=0 fires on the first match. Unmapped address 60 reads 0. Every access acks 1 cycle after strobe.
- Assert wb_rst_i while ARMED at stage 2 -> IDLE, all registers at reset values, no trig_hit_o.
